// File: rtl/lsu_mem_pkg.sv
// Shared types for the lsu_mem load/store scratch memory: access sizes, FSM states,
// response pipeline payload and latency bounds.
package lsu_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned READ_LAT_MIN = 1;
    localparam int unsigned READ_LAT_MAX = 4;

    typedef struct packed {
        logic        vld;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    // Byte lanes touched by an access of the given size at the given low address bits.
    function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: return 4'b0001 << lo;
            SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic addr_misaligned(input size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            SZ_WORD: return lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ld_ext.sv
// Load lane select and sign/zero extension: picks the byte or half addressed by
// lane_i out of a memory word and widens it to 32 bits.
module lsu_ld_ext
    import lsu_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  size_e       size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;

    always_comb begin
        byte_w = 8'(word_i >> {lane_i, 3'b000});
        half_w = lane_i[1] ? word_i[31:16] : word_i[15:0];
        data_o = word_i;
        case (size_i)
            SZ_BYTE: data_o = {{24{~unsigned_i & byte_w[7]}}, byte_w};
            SZ_HALF: data_o = {{16{~unsigned_i & half_w[15]}}, half_w};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem.sv
// Single-port word memory with byte/half/word load-store access and a fixed
// READ_LAT response pipeline. Define LSU_MEM_CLEAR_EN to zero the array after reset.
//
// Handshake: a request is taken on a rising edge with req_valid && req_ready;
// each taken request yields one rsp_valid pulse READ_LAT cycles later, in order,
// and responses cannot be stalled.
module lsu_mem
    import lsu_mem_pkg::*;
#(
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output state_e      dbg_state_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX || DEPTH < 4 ||
        (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
        $error("lsu_mem: illegal DEPTH or READ_LAT");
    end

    logic [31:0] mem_q [DEPTH];
    state_e      state_q, state_d;

    size_e       size;
    logic [AW-1:0] idx;
    logic        range_err, req_err, accept;
    logic [3:0]  wmask;
    logic [31:0] wdata_rep, rd_word, ld_data;
    logic        sweep_done, sweep_we;
    logic [AW-1:0] sweep_idx;
    rsp_t        rsp_in;

    always_comb begin
        size      = size_e'(req_size);
        idx       = req_addr[AW+1:2];
        range_err = |req_addr[31:AW+2];
        req_err   = range_err | addr_misaligned(size, req_addr[1:0]);
        accept    = req_valid & req_ready & reset;
        wmask     = lane_mask(size, req_addr[1:0]);
        rd_word   = mem_q[idx];
        case (size)
            SZ_BYTE: wdata_rep = {4{req_wdata[7:0]}};
            SZ_HALF: wdata_rep = {2{req_wdata[15:0]}};
            default: wdata_rep = req_wdata;
        endcase
    end

`ifdef LSU_MEM_CLEAR_EN
    logic [AW-1:0] clr_q, clr_d;

    always_comb begin
        clr_d = clr_q;
        if (state_q == ST_INIT) clr_d = clr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) clr_q <= '0;
        else        clr_q <= clr_d;
    end

    assign sweep_done = (clr_q == AW'(DEPTH - 1));
    assign sweep_we   = reset & (state_q == ST_INIT);
    assign sweep_idx  = clr_q;
`else
    assign sweep_done = 1'b1;
    assign sweep_we   = 1'b0;
    assign sweep_idx  = '0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_INIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (sweep_done) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        req_ready   = (state_q == ST_RUN);
        dbg_state_o = state_q;
    end

    // Memory is deliberately unreset; only the optional sweep clears it.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem_q[sweep_idx] <= '0;
        end else if (accept && req_we && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem_q[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    lsu_ld_ext u_ld_ext (
        .word_i    (rd_word),
        .lane_i    (req_addr[1:0]),
        .size_i    (size),
        .unsigned_i(req_unsigned),
        .data_o    (ld_data)
    );

    always_comb begin
        rsp_in = '0;
        if (accept) begin
            rsp_in.vld  = 1'b1;
            rsp_in.err  = req_err;
            rsp_in.data = (req_err || req_we) ? 32'h0 : ld_data;
        end
    end

    for (genvar g = 0; g < READ_LAT; g++) begin : g_stage
        rsp_t stg_q;
        if (g == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (!reset) stg_q <= '0;
                else        stg_q <= rsp_in;
            end
        end else begin : g_next
            always_ff @(posedge clk) begin
                if (!reset) stg_q <= '0;
                else        stg_q <= g_stage[g-1].stg_q;
            end
        end
    end

    assign rsp_valid = g_stage[READ_LAT-1].stg_q.vld;
    assign rsp_err   = g_stage[READ_LAT-1].stg_q.err;
    assign rsp_data  = g_stage[READ_LAT-1].stg_q.data;

endmodule
